// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matmul sequencer.
// FSM state encoding, index width and FP32 constants.
package matmul_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_ISSUE,
        S_WAIT,
        S_WR
    } seq_state_t;

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    function automatic logic dim_bad(input logic [IDX_W-1:0] d,
                                     input int max);
        return (d == '0) || (int'(d) > max);
    endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// matmul_idx_counter: nested i/j/k walk with running A/B/C offsets.
// Addresses come from adders only; the FSM drives clear/inc strobes.
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              clear,
    input  logic              inc_k,
    input  logic              inc_elem,
    input  logic [IDX_W-1:0]  dim_m,
    input  logic [IDX_W-1:0]  dim_k,
    input  logic [IDX_W-1:0]  dim_n,
    output logic              k_first,
    output logic              k_last,
    output logic              elem_last,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr
);

    logic [IDX_W-1:0]  i_q, j_q, k_q;
    logic [ADDR_W-1:0] a_row_q, b_off_q, c_row_q;
    logic              j_last;

    assign j_last    = (j_q == dim_n - IDX_W'(1));
    assign k_first   = (k_q == '0);
    assign k_last    = (k_q == dim_k - IDX_W'(1));
    assign elem_last = j_last && (i_q == dim_m - IDX_W'(1));
    assign a_addr    = a_row_q + ADDR_W'(k_q);
    assign b_addr    = b_off_q + ADDR_W'(j_q);
    assign c_addr    = c_row_q + ADDR_W'(j_q);

    // Step k within an element, or advance row-major to the next element
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_row_q <= '0;
            b_off_q <= '0;
            c_row_q <= '0;
        end else if (clear) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_row_q <= '0;
            b_off_q <= '0;
            c_row_q <= '0;
        end else if (inc_k) begin
            k_q     <= k_q + IDX_W'(1);
            b_off_q <= b_off_q + ADDR_W'(dim_n);
        end else if (inc_elem) begin
            k_q     <= '0;
            b_off_q <= '0;
            if (j_last) begin
                j_q     <= '0;
                i_q     <= i_q + IDX_W'(1);
                a_row_q <= a_row_q + ADDR_W'(dim_k);
                c_row_q <= c_row_q + ADDR_W'(dim_n);
            end else begin
                j_q <= j_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_engine_sequencer.sv
// matmul_engine_sequencer: control FSM for one C = A x B job.
// Define MATMUL_SEQ_PERF_CNT_EN to enable the busy-cycle counter.
module matmul_engine_sequencer
    import matmul_pkg::*;
#(
    parameter int MAX_M  = 4,
    parameter int MAX_K  = 4,
    parameter int MAX_N  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        dim_m,
    input  logic [7:0]        dim_k,
    input  logic [7:0]        dim_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              a_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              mac_res_valid,
    input  logic [DATA_W-1:0] mac_res,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    output logic [31:0]       perf_cycles
);

    seq_state_t       state;
    logic [IDX_W-1:0] dm_q, dk_q, dn_q;
    logic             start_acc, kill, bad;
    logic             k_first, k_last, elem_last;
    logic             ctr_clear, ctr_inc_k, ctr_inc_elem;

    assign start_acc = start && !abort && (state == S_IDLE);
    assign kill      = abort && busy;
    assign bad       = dim_bad(dim_m, MAX_M) || dim_bad(dim_k, MAX_K)
                    || dim_bad(dim_n, MAX_N);

    assign ctr_clear    = start_acc || kill
                       || ((state == S_WR) && elem_last);
    assign ctr_inc_k    = !kill && (state == S_ISSUE) && mac_ready
                       && !k_last;
    assign ctr_inc_elem = !kill && (state == S_WR) && !elem_last;

    matmul_idx_counter #(
        .ADDR_W (ADDR_W)
    ) u_idx (
        .s00_axi_aclk    (s00_axi_aclk),
        .s00_axi_aresetn (s00_axi_aresetn),
        .clear           (ctr_clear),
        .inc_k           (ctr_inc_k),
        .inc_elem        (ctr_inc_elem),
        .dim_m           (dm_q),
        .dim_k           (dk_q),
        .dim_n           (dn_q),
        .k_first         (k_first),
        .k_last          (k_last),
        .elem_last       (elem_last),
        .a_addr          (a_addr),
        .b_addr          (b_addr),
        .c_addr          (c_addr)
    );

    // Job sequencing with all strobes and operands registered
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            mac_valid <= 1'b0;
            mac_a     <= DATA_W'(FP32_ZERO);
            mac_b     <= DATA_W'(FP32_ZERO);
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            c_we      <= 1'b0;
            c_wdata   <= DATA_W'(FP32_ZERO);
            dm_q      <= '0;
            dk_q      <= '0;
            dn_q      <= '0;
        end else begin
            a_en <= 1'b0;
            b_en <= 1'b0;
            c_we <= 1'b0;
            if (kill) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                mac_valid <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_acc) begin
                            dm_q <= dim_m;
                            dk_q <= dim_k;
                            dn_q <= dim_n;
                            done <= bad;
                            err  <= bad;
                            if (!bad) begin
                                busy  <= 1'b1;
                                a_en  <= 1'b1;
                                b_en  <= 1'b1;
                                state <= S_RD;
                            end
                        end
                    end
                    S_RD: state <= S_LAT;
                    S_LAT: begin
                        mac_a     <= a_rdata;
                        mac_b     <= b_rdata;
                        mac_first <= k_first;
                        mac_last  <= k_last;
                        mac_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (mac_ready) begin
                            mac_valid <= 1'b0;
                            if (k_last) begin
                                state <= S_WAIT;
                            end else begin
                                a_en  <= 1'b1;
                                b_en  <= 1'b1;
                                state <= S_RD;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (mac_res_valid) begin
                            c_wdata <= mac_res;
                            c_we    <= 1'b1;
                            state   <= S_WR;
                        end
                    end
                    S_WR: begin
                        if (elem_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            a_en  <= 1'b1;
                            b_en  <= 1'b1;
                            state <= S_RD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    // Saturating count of busy cycles, held after the job ends
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
